hc_request_sched: RTL
=====================

Name: hc_request_sched

Overview:
- Shares the CCI-P read and write request channels among the HC_BUFFER_SIZE per-buffer request ports.
- Each port presents one command at a time: read/write, stream or indexed, with an offset. The block resolves it to a cache-line address in the buffer's configured window, bounds-checks it, arbitrates round-robin, and tracks outstanding transactions per port.
- Sits between the per-buffer request FIFOs and the CCI-P tx channels. A run/drain FSM driven by the HC_CONTROL decode sequences it.

Parameters:
- N_PORTS, HC_BUFFER_SIZE (2): number of request ports, one per buffer.
- MAX_OUTSTANDING, 8: per-port limit on in-flight reads plus writes.
- ID_W, $clog2(HC_BUFFER_SIZE)+1: port id width (t_request_cmd_id).

Ports:
- clk  in  1  — the single clock.
- reset_n  in  1  — asynchronous, active-low reset.
- ctl_start  in  1  — pulse; HC_CONTROL_START written.
- ctl_stop  in  1  — pulse; HC_CONTROL_STOP written.
- ctl_clear  in  1  — pulse; HC_CONTROL_ASSERT_RST written.
- buf_cfg  in  N_PORTS*96  — t_hc_buffer per port: 64b byte address, 32b byte size.
- req_valid  in  N_PORTS  — port has a command.
- req_cmd  in  N_PORTS*3  — t_request_cmd.
- req_offset  in  N_PORTS*42  — cache-line offset; indexed commands only.
- req_data  in  N_PORTS*512  — write payload.
- req_ready  out  N_PORTS  — command consumed this cycle.
- c0_almfull  in  1  — CCI-P c0 tx almost-full.
- c1_almfull  in  1  — CCI-P c1 tx almost-full.
- rd_req_valid  out  1  — read request to the CCI-P c0 tx channel.
- rd_req_addr  out  42  — read cache-line address.
- rd_req_mdata  out  16  — read mdata.
- wr_req_valid  out  1  — write request to the CCI-P c1 tx channel.
- wr_req_addr  out  42  — write cache-line address.
- wr_req_data  out  512  — write payload.
- wr_req_mdata  out  16  — write mdata.
- rd_rsp_valid  in  1  — read response returned.
- rd_rsp_mdata  in  16  — read response mdata.
- wr_rsp_valid  in  1  — write response returned.
- wr_rsp_mdata  in  16  — write response mdata.
- running  out  1  — high in S_RUN.
- done  out  1  — high in S_DONE.
- err  out  1  — sticky bounds error.
- err_id  out  ID_W  — port of the first bounds error.

Behaviour:
- Reset: all outputs 0; state S_IDLE; stream pointers, outstanding counters and RR pointer all 0.
- FSM states and transitions:
  - S_IDLE → S_RUN on ctl_start.
  - S_RUN → S_DRAIN on ctl_stop.
  - S_DRAIN → S_DONE when every port's outstanding count is 0. Checked in the same cycle as a final response decrement, so S_DONE is entered on the following edge.
  - S_DONE → S_RUN on ctl_start.
- ctl_clear in any state returns the FSM to S_IDLE and zeroes counters, pointers and err. Requests already issued are not recalled; responses arriving afterwards must not underflow counters (saturate at 0).
- ctl_clear has priority over ctl_start, which has priority over ctl_stop, when they coincide.
- Only S_RUN grants. S_DRAIN/S_DONE/S_IDLE hold req_ready at 0.
- Port eligibility:
  - Read commands: req_valid, !c0_almfull, outstanding < MAX_OUTSTANDING.
  - Write commands: req_valid, !c1_almfull, outstanding < MAX_OUTSTANDING.
  - e_REQUEST_IDLE: always eligible; consumed as a no-op.
- Arbitration: one grant per cycle, round-robin starting at the port after the last grant. req_ready for the granted port is combinational in the grant cycle.
- Address:
  - Line offset is the port's stream pointer for *_STREAM and req_offset for *_INDEXED.
  - addr = buf_cfg.address[47:6] + line offset, modulo 2^42.
  - The stream pointer increments by 1 per granted stream command and is cleared on ctl_start.
- Bounds:
  - Buffer lines = size[31:6] + |size[5:0]|; a command is legal if its line offset < lines.
  - An illegal command is consumed (req_ready=1) with no CCI-P output, and the stream pointer does not advance.
  - err is set; err_id latches the port only if err was 0.
- Latency: rd_req_*/wr_req_* are registered and appear 1 cycle after the grant; valid is high for exactly one cycle. At most one of rd_req_valid and wr_req_valid is high per cycle.
- mdata = {zero pad, port id in [ID_W-1:0]}. Responses decrement the count of port mdata[ID_W-1:0].
- Counters: a grant on the same port in the same cycle as a response leaves the count unchanged. A read response and a write response to the same port in the same cycle decrement by 2.

Decomposition:
- Add to hc_pkg:
  - t_sched_state enum: S_SCHED_IDLE, S_SCHED_RUN, S_SCHED_DRAIN, S_SCHED_DONE.
  - t_outstanding, width $clog2(MAX_OUTSTANDING)+1.
  - HC_MDATA_ID_LSB constant, value 0.
  - HC_SCHED_MAX_OUTSTANDING, value 8.
- One sub-module: hc_rr_arbiter, an N-way round-robin grant from a request vector with pointer update on grant.

Test Plan:
- Port 0 stream read, base 0x1000, size 256 → four grants; rd_req_addr 0x40..0x43, mdata 0.
- Both ports request reads continuously → grants alternate 0,1,0,1; each port stalls after 8 grants until a response with its id returns.
- Port 1 indexed write, offset 5, size 320 (5 lines) → no wr_req_valid, req_ready pulses, err=1, err_id=1. A later port 0 error leaves err_id=1.
- c0_almfull=1 with port 0 read and port 1 write pending → only the port 1 write issues; the read issues the cycle after almfull drops.
- ctl_stop with 3 reads outstanding → S_DRAIN, no grants, done=0. After the third response, done=1 the next cycle.
- reset_n asserted mid-transfer → all outputs 0 asynchronously; after release the FSM is in S_IDLE and ignores req_valid until ctl_start.

Source files
------------

// File: rtl/hc_pkg.sv
// Shared types and constants for the host-channel buffer blocks.
// Covers request commands, buffer descriptors and the request scheduler state.
package hc_pkg;

  localparam int HC_BUFFER_SIZE           = 2;
  localparam int HC_SCHED_MAX_OUTSTANDING = 8;
  localparam int HC_MDATA_ID_LSB          = 0;
  localparam int HC_ID_W                  = $clog2(HC_BUFFER_SIZE) + 1;
  localparam int HC_LINE_ADDR_W           = 42;
  localparam int HC_MDATA_W               = 16;
  localparam int HC_DATA_W                = 512;

  typedef logic [HC_ID_W-1:0]                            t_request_cmd_id;
  typedef logic [$clog2(HC_SCHED_MAX_OUTSTANDING):0]     t_outstanding;
  typedef logic [HC_LINE_ADDR_W-1:0]                     t_line_addr;

  typedef enum logic [2:0] {
    e_REQUEST_IDLE          = 3'd0,
    e_REQUEST_READ_STREAM   = 3'd1,
    e_REQUEST_READ_INDEXED  = 3'd2,
    e_REQUEST_WRITE_STREAM  = 3'd3,
    e_REQUEST_WRITE_INDEXED = 3'd4
  } t_request_cmd;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [1:0] {
    S_SCHED_IDLE,
    S_SCHED_RUN,
    S_SCHED_DRAIN,
    S_SCHED_DONE
  } t_sched_state;

  // A trailing partial line still occupies a whole cache line.
  function automatic logic [26:0] hc_buf_lines(input logic [31:0] size);
    return {1'b0, size[31:6]} + 27'(|size[5:0]);
  endfunction

endpackage

// File: rtl/hc_request_sched_if.sv
// Request-port and CCI-P tx/rx signals of the request scheduler.
// master = the scheduler (it masters the CCI-P tx channels); slave = the environment.
interface hc_request_sched_if #(
  parameter int N_PORTS = hc_pkg::HC_BUFFER_SIZE
);

  logic [N_PORTS-1:0]     req_valid;
  logic [N_PORTS*3-1:0]   req_cmd;
  logic [N_PORTS*42-1:0]  req_offset;
  logic [N_PORTS*512-1:0] req_data;
  logic [N_PORTS-1:0]     req_ready;

  logic                   c0_almfull;
  logic                   c1_almfull;

  logic                   rd_req_valid;
  logic [41:0]            rd_req_addr;
  logic [15:0]            rd_req_mdata;
  logic                   wr_req_valid;
  logic [41:0]            wr_req_addr;
  logic [511:0]           wr_req_data;
  logic [15:0]            wr_req_mdata;

  logic                   rd_rsp_valid;
  logic [15:0]            rd_rsp_mdata;
  logic                   wr_rsp_valid;
  logic [15:0]            wr_rsp_mdata;

  modport master (
    input  req_valid, req_cmd, req_offset, req_data,
    output req_ready,
    input  c0_almfull, c1_almfull,
    output rd_req_valid, rd_req_addr, rd_req_mdata,
    output wr_req_valid, wr_req_addr, wr_req_data, wr_req_mdata,
    input  rd_rsp_valid, rd_rsp_mdata, wr_rsp_valid, wr_rsp_mdata
  );

  modport slave (
    output req_valid, req_cmd, req_offset, req_data,
    input  req_ready,
    output c0_almfull, c1_almfull,
    input  rd_req_valid, rd_req_addr, rd_req_mdata,
    input  wr_req_valid, wr_req_addr, wr_req_data, wr_req_mdata,
    output rd_rsp_valid, rd_rsp_mdata, wr_rsp_valid, wr_rsp_mdata
  );

endinterface

// File: rtl/hc_rr_arbiter.sv
// N-way round-robin arbiter: one grant per cycle, priority starts at the port
// after the most recent grant.
module hc_rr_arbiter #(
  parameter int  N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_id
);

  // Highest-priority port for the next arbitration.
  logic [IDX_W-1:0] ptr;

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search, so no path leaves a latch.
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = IDX_W'(idx);
        gnt[idx]  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (gnt_valid) begin
      ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + 1'b1;
    end
  end

endmodule

// File: rtl/hc_request_sched.sv
// Shares the CCI-P read/write tx channels among the per-buffer request ports:
// address resolution, bounds check, round-robin grant, outstanding tracking.
module hc_request_sched
  import hc_pkg::*;
#(
  parameter int N_PORTS         = HC_BUFFER_SIZE,
  parameter int MAX_OUTSTANDING = HC_SCHED_MAX_OUTSTANDING,
  parameter int ID_W            = $clog2(HC_BUFFER_SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ctl_start,
  input  logic                  ctl_stop,
  input  logic                  ctl_clear,
  input  logic [N_PORTS*96-1:0] buf_cfg,
  hc_request_sched_if.master    bus,
  output logic                  running,
  output logic                  done,
  output logic                  err,
  output logic [ID_W-1:0]       err_id
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  t_sched_state state, state_nxt;
  t_line_addr   stream_ptr  [N_PORTS];
  t_outstanding out_cnt     [N_PORTS];
  t_outstanding out_cnt_nxt [N_PORTS];
  t_line_addr   line_off    [N_PORTS];
  t_line_addr   line_addr   [N_PORTS];
  t_request_cmd cmd         [N_PORTS];

  logic [N_PORTS-1:0] is_rd, is_wr, is_stream, legal, issue, req_vec, gnt;
  logic               gnt_valid, grant_en, all_idle;
  logic [IDX_W-1:0]   gnt_id;

  assign grant_en = (state == S_SCHED_RUN) && !ctl_clear;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    t_hc_buffer cfg;
    logic       room;
    logic       unused_cfg_bits;

    assign cfg             = buf_cfg[p*96 +: 96];
    assign unused_cfg_bits = ^{cfg.address[63:48], cfg.address[5:0]};
    assign cmd[p]          = t_request_cmd'(bus.req_cmd[p*3 +: 3]);
    assign is_rd[p]        = cmd[p] inside {e_REQUEST_READ_STREAM, e_REQUEST_READ_INDEXED};
    assign is_wr[p]        = cmd[p] inside {e_REQUEST_WRITE_STREAM, e_REQUEST_WRITE_INDEXED};
    assign is_stream[p]    = cmd[p] inside {e_REQUEST_READ_STREAM, e_REQUEST_WRITE_STREAM};
    assign line_off[p]     = is_stream[p] ? stream_ptr[p] : bus.req_offset[p*42 +: 42];
    assign legal[p]        = line_off[p] < {15'b0, hc_buf_lines(cfg.size)};
    assign line_addr[p]    = cfg.address[47:6] + line_off[p];
    assign room            = out_cnt[p] < t_outstanding'(MAX_OUTSTANDING);
    assign issue[p]        = gnt[p] && legal[p] && (is_rd[p] || is_wr[p]);

    // Idle/no-op commands need no channel credit and are always consumable.
    assign req_vec[p] = grant_en && bus.req_valid[p] &&
                        (is_rd[p] ? (!bus.c0_almfull && room) :
                         is_wr[p] ? (!bus.c1_almfull && room) : 1'b1);
  end

  hc_rr_arbiter #(.N(N_PORTS)) u_arb (
    .clk       (clk),
    .rst_n     (reset_n),
    .clear     (ctl_clear),
    .req       (req_vec),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign bus.req_ready = gnt;

  // Grants add, responses subtract; stale responses after a clear floor at 0.
  always_comb begin
    int cnt;
    cnt      = 0;
    all_idle = 1'b1;
    for (int p = 0; p < N_PORTS; p++) begin
      cnt = int'(out_cnt[p]);
      if (issue[p]) cnt = cnt + 1;
      if (bus.rd_rsp_valid && bus.rd_rsp_mdata[HC_MDATA_ID_LSB +: ID_W] == ID_W'(p)) cnt = cnt - 1;
      if (bus.wr_rsp_valid && bus.wr_rsp_mdata[HC_MDATA_ID_LSB +: ID_W] == ID_W'(p)) cnt = cnt - 1;
      out_cnt_nxt[p] = (cnt < 0) ? '0 : t_outstanding'(cnt);
      if (out_cnt_nxt[p] != '0) all_idle = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ctl_clear) begin
      state_nxt = S_SCHED_IDLE;
    end else begin
      unique case (state)
        S_SCHED_IDLE:  if (ctl_start) state_nxt = S_SCHED_RUN;
        S_SCHED_RUN:   if (!ctl_start && ctl_stop) state_nxt = S_SCHED_DRAIN;
        S_SCHED_DRAIN: if (all_idle) state_nxt = S_SCHED_DONE;
        S_SCHED_DONE:  if (ctl_start) state_nxt = S_SCHED_RUN;
        default:       state_nxt = S_SCHED_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_SCHED_IDLE;
    else          state <= state_nxt;
  end

  assign running = (state == S_SCHED_RUN);
  assign done    = (state == S_SCHED_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_req_valid <= 1'b0;
      bus.rd_req_addr  <= '0;
      bus.rd_req_mdata <= '0;
      bus.wr_req_valid <= 1'b0;
      bus.wr_req_addr  <= '0;
      bus.wr_req_data  <= '0;
      bus.wr_req_mdata <= '0;
      err              <= 1'b0;
      err_id           <= '0;
      // NOTE: these per-port arrays are a handful of flops, so they are reset; a deep RAM would not be.
      for (int p = 0; p < N_PORTS; p++) begin
        stream_ptr[p] <= '0;
        out_cnt[p]    <= '0;
      end
    end else begin
      bus.rd_req_valid <= 1'b0;
      bus.wr_req_valid <= 1'b0;
      for (int p = 0; p < N_PORTS; p++) begin
        out_cnt[p] <= ctl_clear ? '0 : out_cnt_nxt[p];
      end

      if (gnt_valid) begin
        if (is_rd[gnt_id] && legal[gnt_id]) begin
          bus.rd_req_valid <= 1'b1;
          bus.rd_req_addr  <= line_addr[gnt_id];
          bus.rd_req_mdata <= HC_MDATA_W'(gnt_id) << HC_MDATA_ID_LSB;
        end
        if (is_wr[gnt_id] && legal[gnt_id]) begin
          bus.wr_req_valid <= 1'b1;
          bus.wr_req_addr  <= line_addr[gnt_id];
          bus.wr_req_data  <= bus.req_data[int'(gnt_id)*HC_DATA_W +: HC_DATA_W];
          bus.wr_req_mdata <= HC_MDATA_W'(gnt_id) << HC_MDATA_ID_LSB;
        end
        if (is_stream[gnt_id] && legal[gnt_id]) begin
          stream_ptr[gnt_id] <= stream_ptr[gnt_id] + 1'b1;
        end
        if ((is_rd[gnt_id] || is_wr[gnt_id]) && !legal[gnt_id]) begin
          err <= 1'b1;
          if (!err) err_id <= ID_W'(gnt_id);
        end
      end

      // A start or clear rewinds every stream, overriding a same-cycle advance.
      if (ctl_clear || ctl_start) begin
        for (int p = 0; p < N_PORTS; p++) stream_ptr[p] <= '0;
      end
      if (ctl_clear) begin
        err    <= 1'b0;
        err_id <= '0;
      end
    end
  end

  logic unused_rsp_bits;
  assign unused_rsp_bits = ^{bus.rd_rsp_mdata, bus.wr_rsp_mdata};

endmodule
